// File: rtl/cache_sa_wb_if.sv
// CPU request/response and block-memory signals of the set-associative cache.
// master = CPU plus memory side (the environment); slave = the cache.
interface cache_sa_wb_if #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 16
);
  logic                  reqValid, reqReady, isRead;
  logic [ADDR_W-1:0]     address;
  logic [31:0]           writeData;
  logic                  respValid, isHit;
  logic [31:0]           readData;
  logic                  memReq, memWe, memReady;
  logic [ADDR_W-1:0]     memAddress;
  logic [32*WORDS-1:0]   memWriteData, memReadData;
  logic [WORDS-1:0]      isDirty;
  logic [CNT_W-1:0]      hitCount, missCount;

  modport master (
    output reqValid, isRead, address, writeData, memReady, memReadData,
    input  reqReady, respValid, readData, isHit, memReq, memWe, memAddress,
           memWriteData, isDirty, hitCount, missCount
  );
  modport slave (
    input  reqValid, isRead, address, writeData, memReady, memReadData,
    output reqReady, respValid, readData, isHit, memReq, memWe, memAddress,
           memWriteData, isDirty, hitCount, missCount
  );
endinterface

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement, multi-cycle block memory port and saturating hit/miss counters.
module cache_sa_wb #(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rstN,
  cache_sa_wb_if.slave bus
);
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W  = $clog2(WORDS) + 2;
  localparam int IDX_L  = $clog2(SETS);
  localparam int IDX_W  = (SETS > 1) ? IDX_L : 1;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_L;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state, nxt;

  logic [SETS-1:0][WAYS-1:0]            valid_q;
  logic [SETS-1:0][WAYS-1:0][WORDS-1:0] dirty_q;
  logic [TAG_W-1:0]                     tag_q  [SETS][WAYS];
  logic [WORDS-1:0][31:0]               data_q [SETS][WAYS];
  logic [WAY_W-1:0]                     age_q  [SETS][WAYS];

  logic              req_rd, first_q, hit_q;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata, rdata_q;
  logic [WAY_W-1:0]  vic_q;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  logic [WSEL_W-1:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  assign req_word = WSEL_W'(req_addr >> 2) & WSEL_W'(WORDS - 1);
  assign req_idx  = IDX_W'(req_addr >> OFF_W) & IDX_W'(SETS - 1);
  assign req_tag  = TAG_W'(req_addr >> (OFF_W + IDX_L));

  function automatic logic [ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] t,
                                                 input logic [IDX_W-1:0] i);
    return (ADDR_W'(t) << (OFF_W + IDX_L)) | (ADDR_W'(i) << OFF_W);
  endfunction

  // Tag match plus victim choice: first invalid way, else the oldest way.
  logic             hit, found_inv, vic_dirty;
  logic [WAY_W-1:0] hit_way, vic;
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    vic       = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found_inv && !valid_q[req_idx][w]) begin
        found_inv = 1'b1;
        vic       = WAY_W'(w);
      end
    end
    if (!found_inv)
      for (int w = 0; w < WAYS; w++)
        if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) vic = WAY_W'(w);
    vic_dirty = valid_q[req_idx][vic] && |dirty_q[req_idx][vic];
  end

  always_ff @(posedge clk or negedge rstN)
    if (!rstN) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt              = state;
    bus.reqReady     = 1'b0;
    bus.respValid    = 1'b0;
    bus.memReq       = 1'b0;
    bus.memWe        = 1'b0;
    bus.memAddress   = '0;
    bus.memWriteData = '0;
    bus.isDirty      = '0;
    case (state)
      IDLE: begin
        bus.reqReady = 1'b1;
        if (bus.reqValid) nxt = LOOKUP;
      end
      LOOKUP:
        if (hit)            nxt = RESPOND;
        else if (vic_dirty) nxt = WRITEBACK;
        else                nxt = REFILL;
      WRITEBACK: begin
        bus.memReq       = 1'b1;
        bus.memWe        = 1'b1;
        bus.memAddress   = blk_addr(tag_q[req_idx][vic_q], req_idx);
        bus.memWriteData = data_q[req_idx][vic_q];
        bus.isDirty      = dirty_q[req_idx][vic_q];
        if (bus.memReady) nxt = REFILL;
      end
      REFILL: begin
        bus.memReq     = 1'b1;
        bus.memAddress = blk_addr(req_tag, req_idx);
        if (bus.memReady) nxt = LOOKUP;
      end
      RESPOND: begin
        bus.respValid = 1'b1;
        nxt           = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.readData  = rdata_q;
  assign bus.isHit     = hit_q;
  assign bus.hitCount  = hit_cnt;
  assign bus.missCount = miss_cnt;

  // first_q marks the initial lookup; the lookup after a refill is not counted.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      req_rd    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      first_q   <= 1'b0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
      vic_q     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.reqValid) begin
            req_rd    <= bus.isRead;
            req_addr  <= bus.address;
            req_wdata <= bus.writeData;
            first_q   <= 1'b1;
          end
        LOOKUP: begin
          first_q <= 1'b0;
          if (hit) begin
            if (first_q) begin
              hit_q <= 1'b1;
              if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
            end
            if (req_rd) rdata_q <= data_q[req_idx][hit_way][req_word];
            else begin
              rdata_q <= '0;
              dirty_q[req_idx][hit_way][req_word] <= 1'b1;
            end
            for (int w = 0; w < WAYS; w++)
              if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
            age_q[req_idx][hit_way] <= '0;
          end else begin
            hit_q <= 1'b0;
            vic_q <= vic;
            if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
          end
        end
        REFILL:
          if (bus.memReady) begin
            valid_q[req_idx][vic_q] <= 1'b1;
            dirty_q[req_idx][vic_q] <= '0;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && !req_rd)
      data_q[req_idx][hit_way][req_word] <= req_wdata;
    if (state == REFILL && bus.memReady) begin
      data_q[req_idx][vic_q] <= bus.memReadData;
      tag_q[req_idx][vic_q]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed bench for cache_sa_wb: an LRU-list cache model predicts memory
// transactions and responses, checked every cycle, plus pinned literal values.
module tb_cache_sa_wb;
  localparam int AW = 10, WORDS = 4, SETS = 4, WAYS = 2;

  logic clk = 1'b0, rstN = 1'b0;
  always #5 clk = ~clk;

  cache_sa_wb_if #(.ADDR_W(AW), .WORDS(WORDS), .CNT_W(16)) bus ();
  cache_sa_wb_if #(.ADDR_W(AW), .WORDS(WORDS), .CNT_W(4))  bus2 ();

  cache_sa_wb #(.ADDR_W(AW), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS), .CNT_W(16))
    dut (.clk(clk), .rstN(rstN), .bus(bus));
  cache_sa_wb #(.ADDR_W(AW), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS), .CNT_W(4))
    dut2 (.clk(clk), .rstN(rstN), .bus(bus2));

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory seen by the DUT, and the model's own copy of it.
  logic [31:0] phys_mem [256];
  logic [31:0] mdl_mem  [256];

  typedef struct {logic we; logic [AW-1:0] addr; logic [3:0] mask; logic [127:0] data;} txn_t;
  typedef struct {logic [31:0] rdata; logic hit; logic [15:0] hc; logic [15:0] mc;} rsp_t;
  typedef struct {logic [3:0] tag; logic [3:0][31:0] data; logic [3:0] dirty;} line_t;
  txn_t exp_txn[$];
  rsp_t exp_rsp[$];

  // Each set is a recency list: entry 0 is most recently used.
  line_t ln [SETS][WAYS];
  int    nval [SETS];
  int    m_hit, m_miss;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) nval[s] = 0;
    m_hit = 0; m_miss = 0;
    exp_txn.delete();
    exp_rsp.delete();
  endtask

  task automatic model_access(input bit rd, input logic [AW-1:0] a,
                              input logic [31:0] wd, output bit hit);
    int s, w, f;
    logic [3:0] tg;
    line_t t;
    txn_t x;
    rsp_t r;
    s = int'(a[5:4]); w = int'(a[3:2]); tg = a[9:6];
    f = -1;
    for (int i = 0; i < nval[s]; i++) if (ln[s][i].tag == tg) f = i;
    hit = (f >= 0);
    if (hit) begin
      t = ln[s][f];
      for (int i = f; i > 0; i--) ln[s][i] = ln[s][i-1];
      if (m_hit < 65535) m_hit++;
    end else begin
      if (m_miss < 65535) m_miss++;
      if (nval[s] == WAYS) begin
        t = ln[s][WAYS-1];
        nval[s]--;
        if (t.dirty != 4'b0) begin
          x.we = 1'b1; x.addr = {t.tag, a[5:4], 4'b0}; x.mask = t.dirty; x.data = t.data;
          exp_txn.push_back(x);
          for (int k = 0; k < 4; k++)
            if (t.dirty[k]) mdl_mem[{t.tag, a[5:4], 2'(k)}] = t.data[k];
        end
      end
      x.we = 1'b0; x.addr = {a[9:4], 4'b0}; x.mask = 4'b0; x.data = '0;
      exp_txn.push_back(x);
      t.tag = tg; t.dirty = 4'b0;
      for (int k = 0; k < 4; k++) t.data[k] = mdl_mem[{a[9:4], 2'(k)}];
      for (int i = nval[s]; i > 0; i--) ln[s][i] = ln[s][i-1];
      nval[s]++;
    end
    if (rd) r.rdata = t.data[w];
    else begin
      r.rdata = 32'h0; t.data[w] = wd; t.dirty[w] = 1'b1;
    end
    ln[s][0] = t;
    r.hit = hit; r.hc = 16'(m_hit); r.mc = 16'(m_miss);
    exp_rsp.push_back(r);
  endtask

  // Memory responder: acts shortly after each rising edge, mem_delay idle cycles.
  int mem_delay = 0, mcnt = 0;
  always begin
    @(posedge clk); #2;
    if (bus.memReady) begin
      bus.memReady = 1'b0; mcnt = 0;
    end else if (bus.memReq) begin
      if (mcnt >= mem_delay) begin
        for (int k = 0; k < 4; k++)
          if (bus.memWe) begin
            if (bus.isDirty[k]) phys_mem[int'(bus.memAddress[9:2]) + k] = bus.memWriteData[k*32 +: 32];
          end else bus.memReadData[k*32 +: 32] = phys_mem[int'(bus.memAddress[9:2]) + k];
        bus.memReady = 1'b1;
      end else mcnt++;
    end else mcnt = 0;
  end

  always begin
    @(posedge clk); #2;
    bus2.memReady = bus2.memReq && !bus2.memReady;
  end

  // Compare process: memory side whenever memReq, response side on respValid.
  bit chk_en = 1'b0;
  int wb_seen = 0, req_cycles = 0;
  logic [AW-1:0] last_wb_addr, last_rf_addr;
  logic [3:0]    last_wb_mask;
  logic [31:0]   last_wb_w2, last_rdata;
  logic          last_hit;
  logic [15:0]   last_hc, last_mc;
  always @(negedge clk) begin
    txn_t tx;
    rsp_t rs;
    if (chk_en && rstN) begin
      if (bus.memReq) begin
        req_cycles++;
        check("mem_busy", {bus.reqReady, bus.respValid}, 2'b00);
        check("mem_pending", exp_txn.size() != 0, 1'b1);
        if (exp_txn.size() != 0) begin
          check("mem_we", bus.memWe, exp_txn[0].we);
          check("mem_addr", bus.memAddress, exp_txn[0].addr);
          check("mem_mask", bus.isDirty, exp_txn[0].mask);
          if (exp_txn[0].we) check("mem_wdata", bus.memWriteData, exp_txn[0].data);
          if (bus.memReady) begin
            if (bus.memWe) begin
              wb_seen++;
              last_wb_addr = bus.memAddress;
              last_wb_mask = bus.isDirty;
              last_wb_w2   = bus.memWriteData[95:64];
            end else last_rf_addr = bus.memAddress;
            tx = exp_txn.pop_front();
          end
        end
      end
      if (bus.respValid) begin
        check("rsp_pending", exp_rsp.size() != 0, 1'b1);
        if (exp_rsp.size() != 0) begin
          check("rsp_rdata", bus.readData, exp_rsp[0].rdata);
          check("rsp_hit", bus.isHit, exp_rsp[0].hit);
          check("rsp_hitcnt", bus.hitCount, exp_rsp[0].hc);
          check("rsp_misscnt", bus.missCount, exp_rsp[0].mc);
          rs = exp_rsp.pop_front();
        end
        last_rdata = bus.readData; last_hit = bus.isHit;
        last_hc = bus.hitCount;    last_mc = bus.missCount;
      end
    end
  end

  task automatic do_req(input bit rd, input logic [AW-1:0] a, input logic [31:0] wd, input string name);
    bit hit, got;
    int cyc;
    model_access(rd, a, wd, hit);
    @(negedge clk);
    check({name, "_ready"}, bus.reqReady, 1'b1);
    bus.reqValid = 1'b1; bus.isRead = rd; bus.address = a; bus.writeData = wd;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    cyc = 0; got = 1'b0;
    while (cyc < 200 && !got) begin
      @(negedge clk); cyc++;
      got = bus.respValid;
    end
    check({name, "_resp"}, got, 1'b1);
    if (hit) check({name, "_latency"}, cyc, 2);
    @(posedge clk); #1;
    check({name, "_drained"}, exp_txn.size() + exp_rsp.size(), 0);
  endtask

  task automatic do_req2(input logic [AW-1:0] a);
    int cyc;
    @(negedge clk);
    bus2.reqValid = 1'b1; bus2.isRead = 1'b1; bus2.address = a;
    @(posedge clk); #1;
    bus2.reqValid = 1'b0;
    cyc = 0;
    while (cyc < 100 && !bus2.respValid) begin @(negedge clk); cyc++; end
    check("sat_resp", bus2.respValid, 1'b1);
  endtask

  initial begin
    int wb0, rc0, cyc;
    for (int a = 0; a < 256; a++) phys_mem[a] = 32'h5000_0000 + 32'(a * 4);
    phys_mem[0] = 32'hA; phys_mem[1] = 32'hB; phys_mem[2] = 32'hC; phys_mem[3] = 32'hD;
    for (int a = 0; a < 256; a++) mdl_mem[a] = phys_mem[a];
    bus.reqValid = 0; bus.isRead = 0; bus.address = '0; bus.writeData = '0;
    bus.memReady = 0; bus.memReadData = '0;
    bus2.reqValid = 0; bus2.isRead = 0; bus2.address = '0; bus2.writeData = '0;
    bus2.memReady = 0; bus2.memReadData = '0;
    model_reset();

    #3;
    check("rst_outs", {bus.reqReady, bus.respValid, bus.memReq, bus.isHit, bus.isDirty}, 8'b1000_0000);
    check("rst_cnts", {bus.hitCount, bus.missCount, bus.readData}, 64'h0);
    @(negedge clk); rstN = 1'b1; chk_en = 1'b1;

    do_req(1, 10'h000, 0, "cold");
    check("cold_rdata", last_rdata, 32'hA);
    check("cold_hit", last_hit, 1'b0);
    check("cold_miss", last_mc, 16'd1);
    check("cold_rf_addr", last_rf_addr, 10'h000);
    do_req(1, 10'h004, 0, "hit_rd");
    check("hit_rdata", last_rdata, 32'hB);
    check("hit_cnt", last_hc, 16'd1);

    rc0 = req_cycles;
    do_req(0, 10'h008, 32'h12345678, "wr_hit");
    check("wr_hit_flag", last_hit, 1'b1);
    check("wr_hit_nomem", req_cycles - rc0, 0);
    do_req(1, 10'h008, 0, "rd_back");
    check("rd_back_data", last_rdata, 32'h12345678);

    do_req(1, 10'h040, 0, "fill_w1");
    do_req(1, 10'h000, 0, "touch0");
    wb0 = wb_seen;
    do_req(1, 10'h080, 0, "clean_ev");
    check("clean_ev_nowb", wb_seen - wb0, 0);
    check("clean_ev_rf", last_rf_addr, 10'h080);

    do_req(1, 10'h040, 0, "dirty_ev");
    check("dirty_wb_addr", last_wb_addr, 10'h000);
    check("dirty_wb_mask", last_wb_mask, 4'b0100);
    check("dirty_wb_w2", last_wb_w2, 32'h12345678);
    check("dirty_rf_addr", last_rf_addr, 10'h040);
    check("dirty_miss", last_mc, 16'd4);

    mem_delay = 5; rc0 = req_cycles;
    do_req(1, 10'h100, 0, "slow");
    mem_delay = 0;
    check("slow_cycles", req_cycles - rc0, 6);

    do_req(1, 10'h000, 0, "refetch0");
    do_req(1, 10'h008, 0, "refetch8");
    check("refetch_wb_data", last_rdata, 32'h12345678);

    do_req(0, 10'h014, 32'hCAFEF00D, "wr_miss");
    do_req(0, 10'h01C, 32'h600DBEEF, "wr_hit2");
    do_req(1, 10'h054, 0, "set1_t1");
    do_req(1, 10'h094, 0, "set1_t2");
    check("set1_wb_mask", last_wb_mask, 4'b1010);
    check("set1_wb_addr", last_wb_addr, 10'h010);
    do_req(1, 10'h014, 0, "set1_back");
    check("set1_back_data", last_rdata, 32'hCAFEF00D);

    // Reset while a slow refill is outstanding.
    chk_en = 1'b0; mem_delay = 10;
    @(negedge clk);
    bus.reqValid = 1'b1; bus.isRead = 1'b1; bus.address = 10'h0C0;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    cyc = 0;
    while (cyc < 50 && !bus.memReq) begin @(negedge clk); cyc++; end
    check("mid_memreq", bus.memReq, 1'b1);
    @(negedge clk); #2;
    rstN = 1'b0;
    #1;
    check("mid_rst_outs", {bus.memReq, bus.respValid, bus.reqReady}, 3'b001);
    check("mid_rst_cnts", {bus.hitCount, bus.missCount}, 32'h0);
    model_reset();
    mem_delay = 0;
    @(negedge clk); @(negedge clk);
    rstN = 1'b1; chk_en = 1'b1;
    do_req(1, 10'h0C0, 0, "post_rst");
    check("post_rst_hit", last_hit, 1'b0);
    check("post_rst_miss", last_mc, 16'd1);
    do_req(1, 10'h0C4, 0, "post_rst_hit");
    check("post_rst_hc", last_hc, 16'd1);

    // Narrow counters: one miss then twenty hits.
    do_req2(10'h000);
    for (int i = 0; i < 20; i++) do_req2(10'h004);
    check("sat_hitcnt", bus2.hitCount, 4'd15);
    check("sat_misscnt", bus2.missCount, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
